// File: rtl/alu_64bit_if.sv
// alu_64bit_if: operand/result bundle for the 64-bit ALU.
//   a, b  : 64-bit operands (driven by master)
//   cin   : carry-in to bit 0, only meaningful for ADD/SUB
//   op    : 00 XOR, 01 XNOR, 10 ADD, 11 SUB
//   s     : registered 64-bit result (driven by slave)
//   cout  : registered carry-out of bit 63
// There is no handshake; a new operation is presented every cycle.
interface alu_64bit_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  op;
  logic [63:0] s;
  logic        cout;

  modport master (output a, b, cin, op, input s, cout);
  modport slave  (input a, b, cin, op, output s, cout);
endinterface

// File: rtl/alu_64bit.sv
// alu_64bit: four-function 64-bit ALU (XOR, XNOR, ADD, SUB) built as a
// ripple chain of 64 one-bit slices made only of NAND, OR and XNOR gates.
// Result and carry-out are registered; latency is one clock.
// Ports:
//   clk : rising-edge system clock
//   rst : synchronous active-high reset, clears s and cout
//   bus : alu_64bit_if slave modport (a, b, cin, op in; s, cout out)
// Parameters nand_tpd/or_tpd/xnor_tpd name the per-gate propagation delays
// for timing annotation; they have no functional effect.
module alu_64bit #(
  parameter int nand_tpd = 0,
  parameter int or_tpd   = 0,
  parameter int xnor_tpd = 0
) (
  input  logic       clk,
  input  logic       rst,
  alu_64bit_if.slave bus
);

  // Negative delays are meaningless; catch them at elaboration.
  if (nand_tpd < 0 || or_tpd < 0 || xnor_tpd < 0) begin : g_bad_tpd
    $error("alu_64bit: gate delay parameters must be non-negative");
  end

  // Shared control decode.
  //   nsub : low only for SUB (op=11); used to conditionally invert b.
  //   nop1 : inverted op[1]; op[1] high selects the arithmetic result.
  logic nsub;
  logic nop1;
  nand g_nsub (nsub, bus.op[1], bus.op[0]);
  nand g_nop1 (nop1, bus.op[1], bus.op[1]);

  // Carry into bit 0 is cin gated by op[1], so an undriven cin during a
  // logic op cannot leak into the chain.
  logic cin_n;
  logic [64:0] carry;
  nand g_cin_n (cin_n, bus.op[1], bus.cin);
  nand g_cin   (carry[0], cin_n, cin_n);

  logic [63:0] s_d;

  // One slice per bit. Signal meanings inside slice i:
  //   binv  = b ^ sub           (b inverted for SUB)
  //   p     = ~(a ^ binv)       (propagate, inverted)
  //   x     = a ^ binv
  //   sum   = a ^ binv ^ carry
  //   carry = (a & binv) | (carry_in & x), as a NAND-NAND pair
  //   lr    = x for XOR, ~x for XNOR (selected by op[0])
  //   s_d   = op[1] ? sum : lr, as NAND-fed OR mux
  for (genvar i = 0; i < 64; i++) begin : g_slice
    logic binv, p, x, sum, g_n, t_n, lr;
    logic sel_sum_n, sel_lr_n, sel_sum, sel_lr;

    xnor g_binv (binv, bus.b[i], nsub);
    xnor g_p    (p, bus.a[i], binv);
    nand g_x    (x, p, p);
    xnor g_sum  (sum, p, carry[i]);
    nand g_gn   (g_n, bus.a[i], binv);
    nand g_tn   (t_n, carry[i], x);
    nand g_cy   (carry[i+1], g_n, t_n);
    xnor g_lr   (lr, p, bus.op[0]);

    nand g_ssn  (sel_sum_n, sum, bus.op[1]);
    nand g_sln  (sel_lr_n, lr, nop1);
    nand g_ss   (sel_sum, sel_sum_n, sel_sum_n);
    nand g_sl   (sel_lr, sel_lr_n, sel_lr_n);
    or   g_out  (s_d[i], sel_sum, sel_lr);
  end

  // Carry-out is only meaningful for arithmetic; force it low otherwise.
  logic cout_n;
  logic cout_d;
  nand g_cout_n (cout_n, carry[64], bus.op[1]);
  nand g_cout   (cout_d, cout_n, cout_n);

  // Output register: reset wins over whatever operation is on the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s    <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.s    <= s_d;
      bus.cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_64bit.sv
// tb_alu_64bit: directed vectors for alu_64bit with a queue-based scoreboard.
// The stimulus process drives one operation per cycle on the falling edge and
// pushes the hand-computed expected result; the monitor pops and compares
// shortly after every rising edge.
module tb_alu_64bit;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  alu_64bit_if bus ();

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  alu_64bit #(.nand_tpd(0), .or_tpd(0), .xnor_tpd(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Compare the registered outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.s !== e.s || bus.cout !== e.cout) begin
      failures++;
      $display("[TB] FAIL %s: got s=%h cout=%b, expected s=%h cout=%b",
               e.name, bus.s, bus.cout, e.s, e.cout);
    end
  endtask

  // Drive one operation for the coming rising edge and record what it
  // should produce after that edge.
  task automatic applyStimulus(input string name, input logic r,
                               input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic cin,
                               input logic [63:0] exp_s, input logic exp_cout);
    exp_t e;
    @(negedge clk);
    rst     = r;
    bus.op  = op;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    e.s     = exp_s;
    e.cout  = exp_cout;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Monitor: one result per rising edge once stimulus has started.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    rst     = 1'b1;
    bus.op  = 2'b00;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;

    applyStimulus("reset",      1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1,
                  64'h0, 1'b0);

    applyStimulus("xor_cin0",   1'b0, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 1'b0,
                  64'h0000_FFFF_FFFF_0000, 1'b0);
    applyStimulus("xor_cin1",   1'b0, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 1'b1,
                  64'h0000_FFFF_FFFF_0000, 1'b0);
    applyStimulus("xnor_cin0",  1'b0, 2'b01, 64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 1'b0,
                  64'hFFFF_0000_0000_FFFF, 1'b0);
    applyStimulus("xnor_cin1",  1'b0, 2'b01, 64'h0000_0000_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 1'b1,
                  64'hFFFF_0000_0000_FFFF, 1'b0);
    applyStimulus("xor_cin_x",  1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'bx,
                  64'h0, 1'b0);

    applyStimulus("add_cin0",   1'b0, 2'b10, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    applyStimulus("add_cin1",   1'b0, 2'b10, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
                  64'h0, 1'b1);
    applyStimulus("add_wrap",   1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    applyStimulus("sub_f_9_c1", 1'b0, 2'b11, 64'hF, 64'h9, 1'b1, 64'h6, 1'b1);
    applyStimulus("sub_f_9_c0", 1'b0, 2'b11, 64'hF, 64'h9, 1'b0, 64'h5, 1'b1);
    applyStimulus("sub_1_b_c1", 1'b0, 2'b11, 64'h1, 64'hB, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
    applyStimulus("sub_1_b_c0", 1'b0, 2'b11, 64'h1, 64'hB, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFF5, 1'b0);
    applyStimulus("sub_eq_c1",  1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                  64'h0, 1'b1);
    applyStimulus("sub_eq_c0",  1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    applyStimulus("lat_add",    1'b0, 2'b10, 64'h1, 64'h1, 1'b0, 64'h2, 1'b0);
    applyStimulus("lat_sub",    1'b0, 2'b11, 64'h5, 64'h3, 1'b1, 64'h2, 1'b1);

    applyStimulus("mid_reset",  1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                  64'h0, 1'b0);
    applyStimulus("post_reset", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                  64'h0, 1'b1);

    // Let the monitor drain; leftover entries mean results went missing.
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
